// File: rtl/bullet_pool_pkg.sv
// Shared constants, slot/pool state encodings and bullet record for the multi-shot bullet pool.
package bullet_pool_pkg;

  localparam int NUM_BULLETS     = 4;
  localparam int HRES            = 1280;
  localparam int VRES            = 720;
  localparam int X_W             = 11;
  localparam int Y_W             = 10;
  localparam int BULLET_W        = 4;
  localparam int BULLET_H        = 16;
  localparam int BULLET_SPEED    = 16;
  localparam int PADDLE_W        = 50;
  localparam int PADDLE_H        = 20;
  localparam int COOLDOWN_FRAMES = 8;
  localparam int BULLET_SPAWN_Y  = VRES - PADDLE_H - BULLET_H;
  localparam logic [23:0] BULLET_COLOR = 24'hFFFF00;

  typedef struct packed {
    logic           active;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } bullet_t;

  typedef enum logic {SLOT_IDLE, SLOT_FLYING} slot_state_e;
  typedef enum logic {POOL_READY, POOL_COOLDOWN} pool_state_e;

  // Centre the bullet on the paddle; the sum is one bit wider so it can be clamped at the right edge.
  function automatic logic [X_W-1:0] calc_spawn_x(input logic [X_W-1:0] paddle_x);
    logic [X_W:0] sum;
    sum = {1'b0, paddle_x} + (X_W+1)'((PADDLE_W - BULLET_W) / 2);
    if (sum > (X_W+1)'(HRES - BULLET_W)) return X_W'(HRES - BULLET_W);
    return sum[X_W-1:0];
  endfunction

endpackage

// File: rtl/bullet_pool_slot.sv
// One bullet slot: IDLE/FLYING state, per-frame upward motion, hit clear and raster coverage test.
module bullet_slot
  import bullet_pool_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           spawn_i,
  input  logic [X_W-1:0] spawn_x_i,
  input  logic           tick_i,
  input  logic           hit_i,
  input  logic [X_W-1:0] pix_x_i,
  input  logic [Y_W-1:0] pix_y_i,
  output bullet_t        state_o,
  output logic           pix_hit_o
);

  slot_state_e    st_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [X_W:0]   x_end;
  logic [Y_W:0]   y_end;

  // Spawn is only honoured from IDLE, so a new bullet never moves on its spawn tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q <= SLOT_IDLE;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      case (st_q)
        SLOT_IDLE: begin
          if (spawn_i) begin
            st_q <= SLOT_FLYING;
            x_q  <= spawn_x_i;
            y_q  <= Y_W'(BULLET_SPAWN_Y);
          end
        end
        SLOT_FLYING: begin
          if (hit_i) begin
            st_q <= SLOT_IDLE;
          end else if (tick_i) begin
            if (y_q < Y_W'(BULLET_SPEED)) st_q <= SLOT_IDLE;
            else                          y_q  <= y_q - Y_W'(BULLET_SPEED);
          end
        end
      endcase
    end
  end

  assign x_end = {1'b0, x_q} + (X_W+1)'(BULLET_W);
  assign y_end = {1'b0, y_q} + (Y_W+1)'(BULLET_H);

  always_comb begin
    state_o.active = (st_q == SLOT_FLYING);
    state_o.x      = x_q;
    state_o.y      = y_q;
    pix_hit_o      = (st_q == SLOT_FLYING) &&
                     (pix_x_i >= x_q) && ({1'b0, pix_x_i} < x_end) &&
                     (pix_y_i >= y_q) && ({1'b0, pix_y_i} < y_end);
  end

endmodule

// File: rtl/bullet_pool.sv
// Pool of NUM_BULLETS player bullets: lowest-free-slot allocator, fire cooldown and registered pixel query.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int NUM_BULLETS     = bullet_pool_pkg::NUM_BULLETS,
  parameter int COOLDOWN_FRAMES = bullet_pool_pkg::COOLDOWN_FRAMES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     fire,
  input  logic [X_W-1:0]           paddle_x,
  input  logic [NUM_BULLETS-1:0]   hit_mask,
  input  logic [X_W-1:0]           pix_x,
  input  logic [Y_W-1:0]           pix_y,
  output logic                     pix_on,
  output logic [NUM_BULLETS-1:0]   active,
  output logic [NUM_BULLETS*X_W-1:0] bullet_x,
  output logic [NUM_BULLETS*Y_W-1:0] bullet_y,
  output logic                     fired,
  output logic                     full
);

  localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;

  bullet_t                slot_st [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] pix_hit;
  logic [NUM_BULLETS-1:0] free_mask;
  logic [NUM_BULLETS-1:0] alloc_oh;
  logic [NUM_BULLETS-1:0] spawn_vec;
  logic [X_W-1:0]         spawn_x;
  logic                   spawn_en;
  pool_state_e            pool_q;
  logic [CD_W-1:0]        cd_q;
  logic                   fired_q;
  logic                   pix_on_q;

  // Allocation looks only at the pre-edge mask, so a slot freed this edge is not reused until the next tick.
  assign free_mask = ~active;
  assign alloc_oh  = free_mask & (~free_mask + NUM_BULLETS'(1));
  assign spawn_en  = frame_tick && fire && (pool_q == POOL_READY) && !(&active);
  assign spawn_vec = spawn_en ? alloc_oh : '0;
  assign spawn_x   = calc_spawn_x(paddle_x);

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot u_slot (
      .clk_i     (clk),
      .rst_i     (rst),
      .spawn_i   (spawn_vec[i]),
      .spawn_x_i (spawn_x),
      .tick_i    (frame_tick),
      .hit_i     (hit_mask[i]),
      .pix_x_i   (pix_x),
      .pix_y_i   (pix_y),
      .state_o   (slot_st[i]),
      .pix_hit_o (pix_hit[i])
    );
    assign active[i]               = slot_st[i].active;
    assign bullet_x[i*X_W +: X_W]  = slot_st[i].x;
    assign bullet_y[i*Y_W +: Y_W]  = slot_st[i].y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pool_q   <= POOL_READY;
      cd_q     <= '0;
      fired_q  <= 1'b0;
      pix_on_q <= 1'b0;
    end else begin
      fired_q  <= spawn_en;
      pix_on_q <= |pix_hit;
      if (frame_tick) begin
        case (pool_q)
          POOL_READY: begin
            if (spawn_en) begin
              cd_q <= CD_W'(COOLDOWN_FRAMES - 1);
              if (COOLDOWN_FRAMES > 1) pool_q <= POOL_COOLDOWN;
            end
          end
          POOL_COOLDOWN: begin
            cd_q <= cd_q - CD_W'(1);
            if (cd_q == CD_W'(1)) pool_q <= POOL_READY;
          end
        endcase
      end
    end
  end

  assign fired  = fired_q;
  assign pix_on = pix_on_q;
  // Pure AND of the slot flops, so it changes on the same edge as active.
  assign full   = &active;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench: default pool (cooldown 8) and a cooldown-1 pool share inputs; outputs checked 1 ns after each edge.
module tb_bullet_pool;
  import bullet_pool_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        fire = 1'b0;
  logic [10:0] paddle_x = 11'd600;
  logic [3:0]  hit_mask = 4'h0;
  logic [10:0] pix_x = '0;
  logic [9:0]  pix_y = '0;

  logic        pix_on_a, fired_a, full_a, pix_on_b, fired_b, full_b;
  logic [3:0]  active_a, active_b;
  logic [43:0] bullet_x_a, bullet_x_b;
  logic [39:0] bullet_y_a, bullet_y_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bullet_pool dut_a (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire), .paddle_x(paddle_x),
    .hit_mask(hit_mask), .pix_x(pix_x), .pix_y(pix_y), .pix_on(pix_on_a), .active(active_a),
    .bullet_x(bullet_x_a), .bullet_y(bullet_y_a), .fired(fired_a), .full(full_a)
  );

  bullet_pool #(.NUM_BULLETS(4), .COOLDOWN_FRAMES(1)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .fire(fire), .paddle_x(paddle_x),
    .hit_mask(hit_mask), .pix_x(pix_x), .pix_y(pix_y), .pix_on(pix_on_b), .active(active_b),
    .bullet_x(bullet_x_b), .bullet_y(bullet_y_b), .fired(fired_b), .full(full_b)
  );

  typedef struct {
    logic        tick;
    logic        fire;
    logic [10:0] px;
    logic [9:0]  py;
    logic [3:0]  act;
    logic [9:0]  y0;
    logic        fired;
    logic        pix;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic f, input logic [3:0] h);
    frame_tick = t;
    fire       = f;
    hit_mask   = h;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    hit_mask   = 4'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 4'h0);
    rst = 1'b0;
  endtask

  function automatic logic [9:0] ya(input int i);
    return bullet_y_a[i*10 +: 10];
  endfunction

  function automatic logic [9:0] yb(input int i);
    return bullet_y_b[i*10 +: 10];
  endfunction

  initial begin
    // tick, fire, pix_x, pix_y -> active, slot0 y, fired, pix_on (pix_on reflects pre-edge state)
    vt[0]  = '{1, 1, 11'd0,   10'd0,   4'b0001, 10'd684, 1, 0};
    vt[1]  = '{0, 0, 11'd625, 10'd690, 4'b0001, 10'd684, 0, 1};
    vt[2]  = '{1, 0, 11'd0,   10'd0,   4'b0001, 10'd668, 0, 0};
    vt[3]  = '{1, 0, 11'd0,   10'd0,   4'b0001, 10'd652, 0, 0};
    vt[4]  = '{1, 0, 11'd0,   10'd0,   4'b0001, 10'd636, 0, 0};
    vt[5]  = '{0, 0, 11'd625, 10'd640, 4'b0001, 10'd636, 0, 1};
    vt[6]  = '{0, 0, 11'd627, 10'd640, 4'b0001, 10'd636, 0, 0};
    vt[7]  = '{0, 0, 11'd622, 10'd640, 4'b0001, 10'd636, 0, 0};
    vt[8]  = '{0, 0, 11'd626, 10'd651, 4'b0001, 10'd636, 0, 1};
    vt[9]  = '{0, 0, 11'd626, 10'd652, 4'b0001, 10'd636, 0, 0};
    vt[10] = '{0, 0, 11'd623, 10'd635, 4'b0001, 10'd636, 0, 0};
    vt[11] = '{1, 1, 11'd0,   10'd0,   4'b0001, 10'd620, 0, 0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_active", 32'(active_a), 32'd0);
    chk("rst_bx", 32'(bullet_x_a[10:0]), 32'd0);
    chk("rst_by", 32'(bullet_y_a[9:0]), 32'd0);
    chk("rst_fired", 32'(fired_a), 32'd0);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_pix_on", 32'(pix_on_a), 32'd0);

    // Spawn, flight and pixel boundaries on the default pool
    for (int i = 0; i < 12; i++) begin
      pix_x = vt[i].px;
      pix_y = vt[i].py;
      step(vt[i].tick, vt[i].fire, 4'h0);
      chk($sformatf("vec%0d_active", i), 32'(active_a), 32'(vt[i].act));
      chk($sformatf("vec%0d_y0", i), 32'(ya(0)), 32'(vt[i].y0));
      chk($sformatf("vec%0d_fired", i), 32'(fired_a), 32'(vt[i].fired));
      chk($sformatf("vec%0d_pix_on", i), 32'(pix_on_a), 32'(vt[i].pix));
      if (i == 0) chk("spawn_x0", 32'(bullet_x_a[10:0]), 32'd623);
    end

    // Fire held for 20 ticks with cooldown 8: spawns on ticks 0, 8, 16 into slots 0, 1, 2
    do_reset();
    pix_x = '0;
    pix_y = '0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 4'h0);
      chk($sformatf("hold_fired_t%0d", k), 32'(fired_a), 32'((k % 8) == 0));
      chk($sformatf("hold_active_t%0d", k), 32'(active_a),
          (k < 8) ? 32'h1 : (k < 16) ? 32'h3 : 32'h7);
    end
    chk("hold_y0", 32'(ya(0)), 32'd380);
    chk("hold_y1", 32'(ya(1)), 32'd508);
    chk("hold_y2", 32'(ya(2)), 32'd636);
    chk("hold_full", 32'(full_a), 32'd0);

    // Reset mid-flight with three bullets in the air, raster pointing at slot0
    pix_x = 11'd624;
    pix_y = 10'd385;
    do_reset();
    chk("mid_rst_active", 32'(active_a), 32'd0);
    chk("mid_rst_full", 32'(full_a), 32'd0);
    chk("mid_rst_pix_on", 32'(pix_on_a), 32'd0);
    chk("mid_rst_fired", 32'(fired_a), 32'd0);
    chk("mid_rst_y0", 32'(ya(0)), 32'd0);
    pix_x = '0;
    pix_y = '0;
    step(1'b1, 1'b1, 4'h0);
    chk("post_rst_fired", 32'(fired_a), 32'd1);
    chk("post_rst_active", 32'(active_a), 32'd1);

    // Off-screen exit, same-edge hit versus tick, and hit on an idle slot
    do_reset();
    for (int k = 0; k < 44; k++) begin
      step(1'b1, (k == 0) || (k == 8), (k == 33) ? 4'b0010 : (k == 35) ? 4'b0100 : 4'b0000);
      if (k == 32) chk("two_flying", 32'(active_a), 32'd3);
      if (k == 33) begin
        chk("hit_tick_active", 32'(active_a), 32'd1);
        chk("hit_tick_y1", 32'(ya(1)), 32'd300);
        chk("hit_tick_y0", 32'(ya(0)), 32'd156);
      end
      if (k == 35) chk("idle_hit_active", 32'(active_a), 32'd1);
      if (k == 42) begin
        chk("edge_y0", 32'(ya(0)), 32'd12);
        chk("edge_active", 32'(active_a), 32'd1);
      end
      if (k == 43) begin
        chk("offscreen_active", 32'(active_a), 32'd0);
        chk("offscreen_y0", 32'(ya(0)), 32'd12);
      end
    end

    // Cooldown-1 pool: fill, full, hit frees slot2, refill next tick
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b1, (k == 5) ? 4'b0100 : 4'b0000);
      case (k)
        0: chk("cd1_active_t0", 32'(active_b), 32'h1);
        1: chk("cd1_active_t1", 32'(active_b), 32'h3);
        2: chk("cd1_active_t2", 32'(active_b), 32'h7);
        3: begin
          chk("cd1_active_t3", 32'(active_b), 32'hF);
          chk("cd1_full_t3", 32'(full_b), 32'd1);
        end
        4: chk("cd1_active_t4", 32'(active_b), 32'hF);
        5: begin
          chk("cd1_active_t5", 32'(active_b), 32'hB);
          chk("cd1_full_t5", 32'(full_b), 32'd0);
        end
        default: begin
          chk("cd1_active_t6", 32'(active_b), 32'hF);
          chk("cd1_y2_t6", 32'(yb(2)), 32'd684);
        end
      endcase
      chk($sformatf("cd1_fired_t%0d", k), 32'(fired_b), 32'((k < 4) || (k == 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bullet_pool.md
Name: bullet_pool

Overview:
- Multi-shot successor to the single-bullet logic: manages a parametrised pool of player bullets with spawn, per-frame motion, fire cooldown, collision clear and a raster pixel query.
- Sits between player input, paddle position, the enemy collision logic and the frame compositor.
- Replaces the one-bullet-on-screen limit with NUM_BULLETS independent slots.

Parameters:
- NUM_BULLETS, 4, number of bullet slots (1..16)
- HRES, 1280, horizontal resolution
- VRES, 720, vertical resolution
- X_W, 11, x coordinate width
- Y_W, 10, y coordinate width
- BULLET_W, 4, bullet width in pixels
- BULLET_H, 16, bullet height in pixels
- BULLET_SPEED, 16, pixels moved up per frame
- PADDLE_W, 50, paddle width, used for centring the spawn
- PADDLE_H, 20, paddle height, used for the spawn y
- COOLDOWN_FRAMES, 8, minimum frames between shots (>=1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (vblank start)
- fire  in  1  level; sampled only on frame_tick
- paddle_x  in  X_W  paddle left edge
- hit_mask  in  NUM_BULLETS  per-slot clear request from collision logic
- pix_x  in  X_W  current raster x
- pix_y  in  Y_W  current raster y
- pix_on  out  1  registered: some active bullet covers (pix_x, pix_y)
- active  out  NUM_BULLETS  slot-valid mask
- bullet_x  out  NUM_BULLETS*X_W  packed slot x; slot i at [i*X_W +: X_W]
- bullet_y  out  NUM_BULLETS*Y_W  packed slot y, top edge
- fired  out  1  one-cycle pulse when a spawn occurs
- full  out  1  all slots active

Behaviour:
- Reset: synchronous, active-high. Clears active, bullet_x, bullet_y, cooldown counter, pix_on, fired and full to 0. Also applies when asserted mid-flight: all bullets vanish on the next edge.
- Per-slot FSM: IDLE -> FLYING on spawn.
  - FLYING -> IDLE on hit_mask[i] (any cycle).
  - FLYING -> IDLE on a frame_tick where y < BULLET_SPEED; the bullet leaves the screen and is never wrapped.
  - On any other frame_tick a FLYING slot does y <= y - BULLET_SPEED. x is constant in flight.
- Pool FSM: READY (cooldown == 0) / COOLDOWN (cooldown > 0).
  - On a frame_tick with fire=1, READY, and at least one free slot: spawn into the lowest-index slot that is IDLE before the edge.
  - Spawn position: x = paddle_x + (PADDLE_W-BULLET_W)/2, y = VRES-PADDLE_H-BULLET_H (684 at defaults).
  - On spawn: fired=1 for one cycle and cooldown <= COOLDOWN_FRAMES-1. The pool enters COOLDOWN only if that value is > 0.
  - On a frame_tick with no spawn, a nonzero cooldown decrements by 1.
  - fire while in COOLDOWN or full: ignored; no queuing.
- Simultaneous events:
  - hit_mask beats movement and the off-screen check on the same slot.
  - A slot freed by hit_mask on the same edge is not reallocated that edge, because allocation uses the pre-edge active mask.
  - A freshly spawned bullet does not move on its spawn tick.
  - hit_mask on an IDLE slot has no effect.
- full = &active, registered, updated with active.
- pix_on: 1-cycle latency. pix_on(t+1) = OR over slots of active & x<=pix_x<x+BULLET_W & y<=pix_y<y+BULLET_H, evaluated with the state at cycle t.
- Arithmetic: unsigned compares; bounds widened by 1 bit so x+BULLET_W cannot overflow. The spawn x is computed at X_W+1 bits and saturated to HRES-BULLET_W.

Decomposition:
- Shared package additions: NUM_BULLETS, COOLDOWN_FRAMES, X_W, Y_W, BULLET_SPAWN_Y = VRES-PADDLE_H-BULLET_H, and typedef bullet_t {logic active; logic [X_W-1:0] x; logic [Y_W-1:0] y;}. The existing BULLET_W/H/SPEED/COLOR constants are reused.
- One sub-module, bullet_slot:
  - Holds one bullet_t and implements the per-slot FSM and pixel compare.
  - Inputs: spawn, spawn_x, tick, hit, pix_x, pix_y.
  - Outputs: state, pixel hit.
- The top level instantiates NUM_BULLETS slots plus the allocator (priority encoder), cooldown counter and OR-reduction.

Test Plan:
- Reset, paddle_x=600, fire=1, one frame_tick -> slot0 active, x=623, y=684, fired pulse of 1 cycle, active=4'b0001.
- Continue 3 ticks with fire=0 -> slot0 y=668, 652, 636. Query pix=(625,640) -> pix_on=1 one cycle later; pix=(627,640) -> pix_on=0.
- fire held high for 20 ticks, COOLDOWN_FRAMES=8 -> spawns on ticks 0, 8, 16 only; slots 0, 1, 2 allocated in order.
- COOLDOWN_FRAMES=1, fire held for 5 ticks -> spawns on ticks 0-3, full=1 after the 4th; no fired pulse on tick 4. hit_mask=4'b0100 on tick 5 together with fire -> slot2 cleared, no spawn that tick; spawn into slot2 on tick 6.
- Slot at y=10, frame_tick -> slot goes IDLE with no wrap. Same-cycle hit_mask and frame_tick on a slot at y=300 -> IDLE, y unchanged.
- rst asserted mid-flight with 3 active slots -> next cycle active=0, full=0, pix_on=0, cooldown=0. The first fire tick after release spawns into slot0.
